// File: rtl/led_pwm_ctrl.sv
// LED controller: NUM_CH channels of OFF/ON/PWM/BLINK sharing one prescaler and PWM counter.
// Configured through a word-addressed single-cycle register port with registered read data.
module led_pwm_ctrl #(
   parameter int unsigned NUM_CH         = 8,
   parameter int unsigned PWM_WIDTH      = 8,
   parameter int unsigned PRESCALE_WIDTH = 16
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              wr_en_i,
   input  logic              rd_en_i,
   input  logic [7:0]        addr_i,
   input  logic [31:0]       wdata_i,
   output logic [31:0]       rdata_o,
   output logic              rvalid_o,
   output logic [NUM_CH-1:0] led_o
);

   localparam logic [1:0] ModeOff   = 2'd0;
   localparam logic [1:0] ModeOn    = 2'd1;
   localparam logic [1:0] ModePwm   = 2'd2;
   localparam logic [1:0] ModeBlink = 2'd3;

   localparam logic [7:0] AddrGlobal   = 8'h00;
   localparam logic [7:0] AddrPrescale = 8'h01;

   logic                             enable_q, enable_d;
   logic [PRESCALE_WIDTH-1:0]        prescale_q, prescale_d;
   logic [PRESCALE_WIDTH-1:0]        presc_cnt_q, presc_cnt_d;
   logic [PWM_WIDTH-1:0]             pwm_cnt_q, pwm_cnt_d;
   logic [NUM_CH-1:0][1:0]           mode_q, mode_d;
   logic [NUM_CH-1:0][PWM_WIDTH-1:0] duty_q, duty_d;
   logic [NUM_CH-1:0][PWM_WIDTH-1:0] shadow_q, shadow_d;
   logic [NUM_CH-1:0][PWM_WIDTH-1:0] blink_cnt_q, blink_cnt_d;
   logic [NUM_CH-1:0]                phase_q, phase_d;
   logic [NUM_CH-1:0]                led_q, led_d;
   logic [NUM_CH-1:0]                blink_clr;
   logic [31:0]                      rdata_q, rdata_d, rd_mux;
   logic                             rvalid_q;
   logic                             tick, wrap, presc_wr;
   logic                             unused_wdata;

   assign presc_wr     = wr_en_i && (addr_i == AddrPrescale);
   assign unused_wdata = ^wdata_i;

   always_comb begin
      enable_d   = enable_q;
      prescale_d = prescale_q;
      mode_d     = mode_q;
      duty_d     = duty_q;
      blink_clr  = '0;
      if (wr_en_i && addr_i == AddrGlobal) enable_d = wdata_i[0];
      if (presc_wr) prescale_d = wdata_i[PRESCALE_WIDTH-1:0];
      for (int i = 0; i < NUM_CH; i++) begin
         if (wr_en_i && addr_i == 8'(2 + 2 * i)) begin
            mode_d[i]    = wdata_i[1:0];
            blink_clr[i] = (wdata_i[1:0] == ModeBlink);
         end
         if (wr_en_i && addr_i == 8'(3 + 2 * i)) duty_d[i] = wdata_i[PWM_WIDTH-1:0];
      end
   end

   // Read mux samples current register contents, so a same-cycle write returns the old value
   always_comb begin
      rd_mux = '0;
      if (addr_i == AddrGlobal) rd_mux = {31'd0, enable_q};
      if (addr_i == AddrPrescale) rd_mux = 32'(prescale_q);
      for (int i = 0; i < NUM_CH; i++) begin
         if (addr_i == 8'(2 + 2 * i)) rd_mux = 32'(mode_q[i]);
         if (addr_i == 8'(3 + 2 * i)) rd_mux = 32'(duty_q[i]);
      end
   end

   assign rdata_d = rd_en_i ? rd_mux : rdata_q;

   assign tick = enable_q && (presc_cnt_q == prescale_q);
   assign wrap = tick && (pwm_cnt_q == {PWM_WIDTH{1'b1}});

   always_comb begin
      presc_cnt_d = presc_cnt_q + PRESCALE_WIDTH'(1);
      if (!enable_q || presc_wr || tick) presc_cnt_d = '0;
      pwm_cnt_d = pwm_cnt_q;
      if (!enable_q) begin
         pwm_cnt_d = '0;
      end else if (tick) begin
         pwm_cnt_d = pwm_cnt_q + PWM_WIDTH'(1);
      end
   end

   always_comb begin
      shadow_d    = shadow_q;
      blink_cnt_d = blink_cnt_q;
      phase_d     = phase_q;
      led_d       = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (wrap) shadow_d[i] = duty_q[i];
         // Blink compares against the shadow in effect before this wrap reloads it
         if (!enable_q || blink_clr[i]) begin
            blink_cnt_d[i] = '0;
            phase_d[i]     = 1'b0;
         end else if (wrap) begin
            if (blink_cnt_q[i] == shadow_q[i]) begin
               blink_cnt_d[i] = '0;
               phase_d[i]     = ~phase_q[i];
            end else begin
               blink_cnt_d[i] = blink_cnt_q[i] + PWM_WIDTH'(1);
            end
         end
         unique case (mode_q[i])
            ModeOff:   led_d[i] = 1'b0;
            ModeOn:    led_d[i] = 1'b1;
            ModePwm:   led_d[i] = (pwm_cnt_q < shadow_q[i]);
            ModeBlink: led_d[i] = phase_q[i];
            default:   led_d[i] = 1'b0;
         endcase
         if (!enable_q) led_d[i] = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         enable_q    <= 1'b0;
         prescale_q  <= '0;
         presc_cnt_q <= '0;
         pwm_cnt_q   <= '0;
         mode_q      <= '0;
         duty_q      <= '0;
         shadow_q    <= '0;
         blink_cnt_q <= '0;
         phase_q     <= '0;
         led_q       <= '0;
         rdata_q     <= '0;
         rvalid_q    <= 1'b0;
      end else begin
         enable_q    <= enable_d;
         prescale_q  <= prescale_d;
         presc_cnt_q <= presc_cnt_d;
         pwm_cnt_q   <= pwm_cnt_d;
         mode_q      <= mode_d;
         duty_q      <= duty_d;
         shadow_q    <= shadow_d;
         blink_cnt_q <= blink_cnt_d;
         phase_q     <= phase_d;
         led_q       <= led_d;
         rdata_q     <= rdata_d;
         rvalid_q    <= rd_en_i;
      end
   end

   assign rdata_o  = rdata_q;
   assign rvalid_o = rvalid_q;
   assign led_o    = led_q;

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Bench for led_pwm_ctrl: per-cycle comparison against a behavioural model plus directed
// literal checks of PWM duty, shadowing, blink timing, disable and out-of-range access.
module tb_led_pwm_ctrl;

   localparam int NUM_CH = 8;
   localparam int PWM_WIDTH = 8;
   localparam int PRESCALE_WIDTH = 16;
   localparam int PERIOD = 1 << PWM_WIDTH;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              wr_en, rd_en;
   logic [7:0]        addr;
   logic [31:0]       wdata;
   logic [31:0]       rdata;
   logic              rvalid;
   logic [NUM_CH-1:0] led;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   led_pwm_ctrl #(
      .NUM_CH(NUM_CH),
      .PWM_WIDTH(PWM_WIDTH),
      .PRESCALE_WIDTH(PRESCALE_WIDTH)
   ) dut (
      .clk_i(clk),
      .rst_ni(rst_n),
      .wr_en_i(wr_en),
      .rd_en_i(rd_en),
      .addr_i(addr),
      .wdata_i(wdata),
      .rdata_o(rdata),
      .rvalid_o(rvalid),
      .led_o(led)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural model: ticks since enable give the PWM position; registers as plain ints
   int m_en, m_prescale, m_pcnt, m_ticks;
   int m_mode[NUM_CH], m_duty[NUM_CH], m_shadow[NUM_CH], m_bcnt[NUM_CH], m_phase[NUM_CH];
   logic [NUM_CH-1:0] exp_led = '0;
   logic [31:0]       exp_rdata = '0;
   logic              exp_rvalid = 1'b0;
   bit                m_tick, m_wrap;
   int                m_pwm;

   function automatic logic [31:0] model_read(input int a);
      if (a == 0) return 32'(m_en);
      if (a == 1) return 32'(m_prescale);
      if (a >= 2 && a < 2 + 2 * NUM_CH) begin
         if (a % 2 == 0) return 32'(m_mode[(a - 2) / 2]);
         return 32'(m_duty[(a - 2) / 2]);
      end
      return 32'd0;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_en = 0; m_prescale = 0; m_pcnt = 0; m_ticks = 0;
         for (int c = 0; c < NUM_CH; c++) begin
            m_mode[c] = 0; m_duty[c] = 0; m_shadow[c] = 0; m_bcnt[c] = 0; m_phase[c] = 0;
         end
         exp_led = '0; exp_rdata = '0; exp_rvalid = 1'b0;
      end else begin
         m_pwm  = m_ticks % PERIOD;
         m_tick = (m_en != 0) && (m_pcnt == m_prescale);
         m_wrap = m_tick && (m_pwm == PERIOD - 1);
         for (int c = 0; c < NUM_CH; c++) begin
            if (m_en == 0) exp_led[c] = 1'b0;
            else if (m_mode[c] == 1) exp_led[c] = 1'b1;
            else if (m_mode[c] == 2) exp_led[c] = (m_pwm < m_shadow[c]);
            else if (m_mode[c] == 3) exp_led[c] = (m_phase[c] != 0);
            else exp_led[c] = 1'b0;
         end
         exp_rvalid = rd_en;
         if (rd_en) exp_rdata = model_read(int'(addr));
         for (int c = 0; c < NUM_CH; c++) begin
            if (m_en == 0) begin
               m_bcnt[c] = 0; m_phase[c] = 0;
            end else if (m_wrap) begin
               if (m_bcnt[c] == m_shadow[c]) begin
                  m_bcnt[c] = 0; m_phase[c] = 1 - m_phase[c];
               end else begin
                  m_bcnt[c] = (m_bcnt[c] + 1) % PERIOD;
               end
            end
            if (m_wrap) m_shadow[c] = m_duty[c];
         end
         if (m_en == 0 || m_tick || (wr_en && addr == 8'd1)) m_pcnt = 0;
         else m_pcnt++;
         if (m_en == 0) m_ticks = 0;
         else if (m_tick) m_ticks++;
         if (wr_en) begin
            int a;
            a = int'(addr);
            if (a == 0) m_en = int'(wdata & 32'h1);
            else if (a == 1) m_prescale = int'(wdata & 32'hFFFF);
            else if (a < 2 + 2 * NUM_CH) begin
               if (a % 2 == 0) begin
                  m_mode[(a - 2) / 2] = int'(wdata & 32'h3);
                  if ((wdata & 32'h3) == 32'h3) begin
                     m_bcnt[(a - 2) / 2] = 0; m_phase[(a - 2) / 2] = 0;
                  end
               end else begin
                  m_duty[(a - 2) / 2] = int'(wdata & 32'hFF);
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("led", 32'(led), 32'(exp_led));
         check("rvalid", 32'(rvalid), 32'(exp_rvalid));
         check("rdata", rdata, exp_rdata);
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      wr_en = 1'b1; addr = a; wdata = d;
      step(1);
      wr_en = 1'b0;
   endtask

   task automatic rd(input logic [7:0] a, output logic [31:0] d);
      rd_en = 1'b1; addr = a;
      step(1);
      rd_en = 1'b0;
      d = rdata;
      check("rd_rvalid", 32'(rvalid), 32'd1);
   endtask

   task automatic count_high(input int ch, input int n, output int hi);
      hi = 0;
      repeat (n) begin
         step(1);
         if (led[ch]) hi++;
      end
   endtask

   task automatic wait_toggle(input int ch, input int limit, output int n);
      logic prev;
      prev = led[ch];
      n = 0;
      while (n < limit) begin
         step(1);
         n++;
         if (led[ch] !== prev) return;
      end
      n = -1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      int hi, n;
      wr_en = 1'b0; rd_en = 1'b0; addr = '0; wdata = '0; rst_n = 1'b1;
      #2 rst_n = 1'b0;
      chk_en = 1'b1;
      #1;
      check("reset_led", 32'(led), 32'd0);
      check("reset_rvalid", 32'(rvalid), 32'd0);
      check("reset_rdata", rdata, 32'd0);
      step(3);
      rst_n = 1'b1;
      step(1);

      wr(8'h02, 32'd2);
      wr(8'h03, 32'h40);
      rd(8'h02, d); check("rd_mode0", d, 32'd2);
      rd(8'h03, d); check("rd_duty0", d, 32'h40);

      wr(8'h01, 32'd0);
      wr(8'h00, 32'd1);
      step(512);
      count_high(0, 256, hi); check("pwm_duty40_highs", 32'(hi), 32'd64);

      n = 0;
      while ((m_ticks % PERIOD) != 'h80 && n < 600) begin
         step(1);
         n++;
      end
      check("pwm_align", 32'(n < 600), 32'd1);
      wr(8'h03, 32'h10);
      count_high(0, 100, hi); check("shadow_hold", 32'(hi), 32'd0);
      step(200);
      count_high(0, 256, hi); check("shadow_duty10_highs", 32'(hi), 32'd16);
      wr(8'h03, 32'd0);
      step(512);
      count_high(0, 256, hi); check("pwm_duty0_highs", 32'(hi), 32'd0);

      wr(8'h01, 32'd1);
      wr(8'h08, 32'd3);
      wr(8'h09, 32'd1);
      wait_toggle(3, 3000, n); check("blink_edge1", 32'(n > 0), 32'd1);
      wait_toggle(3, 3000, n); check("blink_edge2", 32'(n > 0), 32'd1);
      wait_toggle(3, 3000, n); check("blink_halfperiod", 32'(n), 32'd1024);
      check("blink_phase_high", 32'(led[3]), 32'd1);
      wr(8'h08, 32'd3);
      step(1);
      check("blink_restart_phase", 32'(led[3]), 32'd0);
      count_high(3, 500, hi); check("blink_restart_hold", 32'(hi), 32'd0);

      wr(8'h04, 32'd1);
      step(1);
      check("on_led1", 32'(led[1]), 32'd1);
      wr(8'h00, 32'd0);
      step(1);
      check("disable_led1", 32'(led[1]), 32'd0);
      rd(8'h04, d); check("disable_rd_mode1", d, 32'd1);
      wr(8'h00, 32'd1);
      check("reenable_led1_t0", 32'(led[1]), 32'd0);
      step(1);
      check("reenable_led1_t1", 32'(led[1]), 32'd1);

      wr(8'hF0, 32'hFF);
      rd(8'hF0, d); check("oor_rdata", d, 32'd0);
      rd(8'h02, d); check("oor_mode0_kept", d, 32'd2);
      rd(8'h09, d); check("oor_duty3_kept", d, 32'd1);

      rd_en = 1'b1; addr = 8'h02;
      step(1);
      rd_en = 1'b0;
      check("pre_reset_rvalid", 32'(rvalid), 32'd1);
      rst_n = 1'b0;
      #1;
      check("midreset_led", 32'(led), 32'd0);
      check("midreset_rvalid", 32'(rvalid), 32'd0);
      check("midreset_rdata", rdata, 32'd0);
      step(2);
      rst_n = 1'b1;
      step(1);
      rd(8'h02, d); check("post_reset_mode0", d, 32'd0);
      rd(8'h00, d); check("post_reset_global", d, 32'd0);

      for (int i = 0; i < 4000; i++) begin
         logic [7:0] a;
         logic [31:0] v;
         wr_en = ($urandom_range(0, 3) == 0);
         rd_en = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 9) == 0) a = 8'($urandom_range(0, 255));
         else a = 8'($urandom_range(0, 19));
         v = $urandom();
         if (a == 8'h00) v = {$urandom_range(0, 1) == 0 ? 16'hA5A4 : 16'h0, 15'd0,
                               1'($urandom_range(0, 7) != 0)};
         else if (a == 8'h01) v = (v & 32'hFFFF_0000) | 32'($urandom_range(0, 2));
         else if (a[0] && $urandom_range(0, 1) == 0) v = (v & 32'hFFFF_FF00) |
                                                          32'($urandom_range(0, 3));
         addr = a;
         wdata = v;
         step(1);
      end
      wr_en = 1'b0;
      rd_en = 1'b0;
      step(4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/led_pwm_ctrl.md
Name: led_pwm_ctrl

Overview:
Parametrised successor to the single-bit LED output of the priRV32 top level. Drives NUM_CH LED outputs, each independently configurable as OFF, ON, PWM dimming or BLINK. Configured over a simple synchronous register port from the core's memory-mapped I/O decoder. Shares one prescaler and one PWM period counter across all channels.

Parameters:
NUM_CH, 8, number of LED channels (1..32)
PWM_WIDTH, 8, PWM counter and duty width in bits; PWM period is 2^PWM_WIDTH ticks
PRESCALE_WIDTH, 16, prescaler reload register width

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
wr_en  input  1  register write strobe, single-cycle
rd_en  input  1  register read strobe, single-cycle
addr  input  8  word address
wdata  input  32  write data
rdata  output  32  read data, registered
rvalid  output  1  high for one cycle when rdata is valid
led  output  NUM_CH  LED outputs, registered

Behaviour:
- Reset is asynchronous and active-low, applied on rst_n low. All registers, counters, shadows, blink state, led, rdata and rvalid reset to 0.
- Register map (word addresses):
  - 0x00 GLOBAL: bit0 enable.
  - 0x01 PRESCALE: [PRESCALE_WIDTH-1:0].
  - 0x02+2*ch MODE: [1:0], with 0=OFF, 1=ON, 2=PWM, 3=BLINK.
  - 0x03+2*ch DUTY: [PWM_WIDTH-1:0].
  - Unused write bits are ignored; unused read bits return 0.
  - Addresses beyond 0x03+2*(NUM_CH-1): writes ignored, reads return 0 with rvalid still asserted.
- Read timing: rd_en in cycle N gives rdata/rvalid in cycle N+1. rdata holds its value until the next read. A read and a write to the same address in the same cycle returns the old value.
- Prescaler:
  - Counts 0..PRESCALE, then returns to 0.
  - tick asserts in the cycle the count equals PRESCALE. PRESCALE=0 gives a tick every cycle.
  - Writing PRESCALE clears the prescaler count.
- PWM counter: increments on tick and wraps from 2^PWM_WIDTH-1 to 0. wrap = tick while the counter is at its maximum.
- Duty shadowing: each channel holds a shadow duty, loaded from DUTY on wrap. Mid-period DUTY writes never glitch the output.
- Channel output, registered, so led changes one cycle after the condition:
  - OFF: 0.
  - ON: 1.
  - PWM: pwm_cnt < shadow_duty. Duty 0 gives always 0. Maximum duty gives 1 for 2^PWM_WIDTH-1 of 2^PWM_WIDTH ticks.
  - BLINK: per-channel blink counter increments on each wrap. When it equals shadow_duty it clears and the phase toggles. led = phase, so the half-period is (DUTY+1) PWM periods.
- Writing MODE to BLINK, from any mode including BLINK, clears that channel's blink counter and phase.
- Global enable = 0:
  - led forced to 0.
  - Prescaler, PWM counter and blink state held at 0.
  - Register writes and reads remain functional.
- Enable 0 -> 1: counting starts from 0 on the next cycle.
- Reset mid-operation: immediate return to the reset state. No partial register writes survive.

Test Plan:
- Reset/readback: assert rst_n low mid-run -> led=0, rvalid=0. After release, write MODE0=2 and DUTY0=0x40, then read both -> rdata 0x2 then 0x40, each one cycle after rd_en.
- PWM duty: enable=1, PRESCALE=0, ch0 PWM DUTY=0x40 -> led[0] high for exactly 64 of every 256 cycles, steady after the first wrap. DUTY=0 -> constant 0.
- Shadow update: write DUTY0=0x10 at pwm_cnt=0x80 -> no change to led[0] until the next wrap, then 16-cycle high pulses.
- Blink with prescale: PRESCALE=1, PWM_WIDTH=8, ch3 BLINK DUTY=1 -> led[3] toggles every 2*256*2=1024 cycles. Rewriting MODE3=3 restarts with phase 0.
- Global disable: ch1 ON, enable=0 -> led[1]=0 while reads still return MODE1=1. Re-enable -> led[1]=1 one cycle later.
- Out-of-range access: write 0xFF to addr 0xF0, then read it -> rdata=0, rvalid=1, no channel state changed.
